// File: rtl/bcd_stopwatch_counter.sv
// Six-digit BCD hh:mm:ss stopwatch driven by a 1 Hz prescaler, with pause,
// clear, and a lap snapshot register set for the lower display row.
module bcd_stopwatch_counter #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       PAUSE_sw,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_1s,
    output logic [3:0] sec_10s,
    output logic [3:0] min_1s,
    output logic [3:0] min_10s,
    output logic [3:0] hr_1s,
    output logic [3:0] hr_10s,
    output logic [3:0] lap_sec_1s,
    output logic [3:0] lap_sec_10s,
    output logic [3:0] lap_min_1s,
    output logic [3:0] lap_min_10s,
    output logic [3:0] lap_hr_1s,
    output logic [3:0] lap_hr_10s,
    output logic       tick_1Hz,
    output logic       rollover
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]       MAX_UNITS  = 4'd9;
    localparam logic [3:0]       MAX_TENS   = 4'd5;

    logic [CNT_W-1:0] r_presc;
    logic [3:0]       r_sec_1s, r_sec_10s, r_min_1s, r_min_10s, r_hr_1s, r_hr_10s;
    logic [3:0]       r_lap_sec_1s, r_lap_sec_10s, r_lap_min_1s;
    logic [3:0]       r_lap_min_10s, r_lap_hr_1s, r_lap_hr_10s;
    logic             r_tick;
    logic             r_rollover;

    logic             w_terminal;
    logic             w_inc;
    logic             w_c1, w_c2, w_c3, w_c4, w_c5, w_wrap;
    logic [3:0]       w_sec_1s, w_sec_10s, w_min_1s, w_min_10s, w_hr_1s, w_hr_10s;

    // Advance one digit when its carry-in is set, wrapping at its maximum.
    function automatic logic [3:0] adv(input logic [3:0] d, input logic en,
                                       input logic [3:0] dmax);
        if (!en)
            return d;
        return (d == dmax) ? 4'd0 : d + 4'd1;
    endfunction

    // Carry chain is fully combinational so all digits move on one edge.
    always_comb begin
        w_terminal = (r_presc == PRESC_LAST);
        w_inc      = w_terminal && !PAUSE_sw && !clear;
        w_c1       = w_inc && (r_sec_1s  == MAX_UNITS);
        w_c2       = w_c1  && (r_sec_10s == MAX_TENS);
        w_c3       = w_c2  && (r_min_1s  == MAX_UNITS);
        w_c4       = w_c3  && (r_min_10s == MAX_TENS);
        w_c5       = w_c4  && (r_hr_1s   == MAX_UNITS);
        w_wrap     = w_c5  && (r_hr_10s  == MAX_UNITS);
        w_sec_1s   = adv(r_sec_1s,  w_inc, MAX_UNITS);
        w_sec_10s  = adv(r_sec_10s, w_c1,  MAX_TENS);
        w_min_1s   = adv(r_min_1s,  w_c2,  MAX_UNITS);
        w_min_10s  = adv(r_min_10s, w_c3,  MAX_TENS);
        w_hr_1s    = adv(r_hr_1s,   w_c4,  MAX_UNITS);
        w_hr_10s   = adv(r_hr_10s,  w_c5,  MAX_UNITS);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc       <= '0;
            r_sec_1s      <= '0;
            r_sec_10s     <= '0;
            r_min_1s      <= '0;
            r_min_10s     <= '0;
            r_hr_1s       <= '0;
            r_hr_10s      <= '0;
            r_lap_sec_1s  <= '0;
            r_lap_sec_10s <= '0;
            r_lap_min_1s  <= '0;
            r_lap_min_10s <= '0;
            r_lap_hr_1s   <= '0;
            r_lap_hr_10s  <= '0;
            r_tick        <= 1'b0;
            r_rollover    <= 1'b0;
        end else begin
            r_tick     <= w_inc;
            r_rollover <= w_wrap;
            // Lap samples the pre-edge digits, so it sees pre-clear/pre-increment time.
            if (lap) begin
                r_lap_sec_1s  <= r_sec_1s;
                r_lap_sec_10s <= r_sec_10s;
                r_lap_min_1s  <= r_min_1s;
                r_lap_min_10s <= r_min_10s;
                r_lap_hr_1s   <= r_hr_1s;
                r_lap_hr_10s  <= r_hr_10s;
            end
            if (clear) begin
                r_presc   <= '0;
                r_sec_1s  <= '0;
                r_sec_10s <= '0;
                r_min_1s  <= '0;
                r_min_10s <= '0;
                r_hr_1s   <= '0;
                r_hr_10s  <= '0;
            end else begin
                if (!PAUSE_sw)
                    r_presc <= w_terminal ? '0 : r_presc + CNT_W'(1);
                r_sec_1s  <= w_sec_1s;
                r_sec_10s <= w_sec_10s;
                r_min_1s  <= w_min_1s;
                r_min_10s <= w_min_10s;
                r_hr_1s   <= w_hr_1s;
                r_hr_10s  <= w_hr_10s;
            end
        end
    end

    assign sec_1s      = r_sec_1s;
    assign sec_10s     = r_sec_10s;
    assign min_1s      = r_min_1s;
    assign min_10s     = r_min_10s;
    assign hr_1s       = r_hr_1s;
    assign hr_10s      = r_hr_10s;
    assign lap_sec_1s  = r_lap_sec_1s;
    assign lap_sec_10s = r_lap_sec_10s;
    assign lap_min_1s  = r_lap_min_1s;
    assign lap_min_10s = r_lap_min_10s;
    assign lap_hr_1s   = r_lap_hr_1s;
    assign lap_hr_10s  = r_lap_hr_10s;
    assign tick_1Hz    = r_tick;
    assign rollover    = r_rollover;

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Scoreboarded bench: a seconds-count reference model predicts every cycle's
// outputs; a monitor compares them one cycle after each stimulus.
module tb_bcd_stopwatch_counter;

    localparam int unsigned TPS      = 4;
    localparam int          DAY_SECS = 100 * 3600;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       PAUSE_sw = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
    logic [3:0] lap_sec_1s, lap_sec_10s, lap_min_1s, lap_min_10s, lap_hr_1s, lap_hr_10s;
    logic       tick_1Hz, rollover;

    bcd_stopwatch_counter #(.TICKS_PER_SEC(TPS), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .PAUSE_sw(PAUSE_sw), .clear(clear), .lap(lap),
        .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
        .hr_1s(hr_1s), .hr_10s(hr_10s),
        .lap_sec_1s(lap_sec_1s), .lap_sec_10s(lap_sec_10s), .lap_min_1s(lap_min_1s),
        .lap_min_10s(lap_min_10s), .lap_hr_1s(lap_hr_1s), .lap_hr_10s(lap_hr_10s),
        .tick_1Hz(tick_1Hz), .rollover(rollover)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] run;
        logic [23:0] lapd;
        logic        tick;
        logic        roll;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: elapsed seconds, prescaler phase, lap seconds.
    int   m_t = 0;
    int   m_phase = 0;
    int   m_lap = 0;
    logic [23:0] pre_bcd;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    endtask

    // One clock of stimulus; optionally preloads the running digits first.
    task automatic step(input logic rst, input logic pse, input logic clr, input logic lp,
                        input bit pre = 1'b0, input int pre_t = 0);
        exp_t e;
        bit   inc;
        @(negedge clk);
        if (pre) begin
            pre_bcd = to_bcd(pre_t);
            force dut.r_hr_10s  = pre_bcd[23:20];
            force dut.r_hr_1s   = pre_bcd[19:16];
            force dut.r_min_10s = pre_bcd[15:12];
            force dut.r_min_1s  = pre_bcd[11:8];
            force dut.r_sec_10s = pre_bcd[7:4];
            force dut.r_sec_1s  = pre_bcd[3:0];
            #1;
            release dut.r_hr_10s;
            release dut.r_hr_1s;
            release dut.r_min_10s;
            release dut.r_min_1s;
            release dut.r_sec_10s;
            release dut.r_sec_1s;
            m_t = pre_t;
        end
        reset_n  = rst;
        PAUSE_sw = pse;
        clear    = clr;
        lap      = lp;
        e.roll = 1'b0;
        e.tick = 1'b0;
        if (!rst) begin
            m_t = 0; m_phase = 0; m_lap = 0;
        end else begin
            if (lp) m_lap = m_t;
            inc = (m_phase == int'(TPS) - 1) && !pse && !clr;
            if (clr) begin
                m_t = 0; m_phase = 0;
            end else if (!pse) begin
                m_phase = (m_phase + 1) % int'(TPS);
                if (inc) begin
                    m_t = m_t + 1;
                    if (m_t == DAY_SECS) begin
                        m_t = 0;
                        e.roll = 1'b1;
                    end
                end
            end
            e.tick = inc;
        end
        e.run  = to_bcd(m_t);
        e.lapd = to_bcd(m_lap);
        exp_q.push_back(e);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every edge the DUT presents a new output set; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("running", {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s}, e.run);
                check("lap", {lap_hr_10s, lap_hr_1s, lap_min_10s, lap_min_1s,
                              lap_sec_10s, lap_sec_1s}, e.lapd);
                check("tick_roll", {22'd0, tick_1Hz, rollover}, {22'd0, e.tick, e.roll});
            end
        end
    end

    initial begin
        int guard;
        // Reset values
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        // 40 free-running cycles -> 00:00:10
        run_idle(40);
        // Pause for 10 cycles starting 2 cycles after a tick
        run_idle(2);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        run_idle(8);
        // Pause rising exactly on the terminal cycle
        guard = 0;
        while (m_phase != int'(TPS) - 1 && guard < 10) begin run_idle(1); guard++; end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        run_idle(5);
        // Clear, then reach 00:00:07 on a terminal cycle; lap+clear together
        step(1'b1, 1'b0, 1'b1, 1'b0);
        guard = 0;
        while (!(m_t == 7 && m_phase == int'(TPS) - 1) && guard < 100) begin
            run_idle(1); guard++;
        end
        step(1'b1, 1'b0, 1'b1, 1'b1);
        run_idle(6);
        // Natural carry 00:00:59 -> 00:01:00
        run_idle(60 * int'(TPS));
        // Preloaded boundaries: minute, hour, ten-hour and full rollover
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 59 * 60 + 58);
        run_idle(12);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9 * 3600 + 59 * 60 + 58);
        run_idle(12);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DAY_SECS - 2);
        run_idle(12);
        // Lap at 00:12:30, reset mid-count at 00:12:34
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12 * 60 + 30);
        guard = 0;
        while (m_t != 12 * 60 + 34 && guard < 40) begin run_idle(1); guard++; end
        run_idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        run_idle(8);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 299) == 0), int'($urandom_range(0, DAY_SECS - 1)));
        end
        run_idle(2);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
